param_mux_scan: RTL

Parametrised N-channel, DW-bit multiplexer with a registered output. It has two modes.
- Manual mode: channel chosen directly by sel, output registered with 1-cycle latency.
- Scan mode: a start pulse triggers one sweep across the enabled channels in ascending order, holding each for a programmable dwell time and emitting one tagged sample per channel.

It generalises the single-bit 8:1 selector and sits between multi-channel sources and a single downstream consumer.

---
 rtl/param_mux_scan_if.sv | 29 ++
 rtl/param_mux_scan.sv | 112 +++++++++++
 2 files changed

// File: rtl/param_mux_scan_if.sv
// rtl/param_mux_scan_if.sv - channel data, control and registered output bundle for param_mux_scan
interface param_mux_scan_if #(
    parameter int N_CH    = 8,
    parameter int DW      = 8,
    parameter int DWELL_W = 8
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH*DW-1:0] din;
    logic [SEL_W-1:0]   sel;
    logic               mode;
    logic               start;
    logic [DWELL_W-1:0] dwell;
    logic [N_CH-1:0]    en_mask;
    logic [DW-1:0]      dout;
    logic [SEL_W-1:0]   dout_ch;
    logic               dout_valid;
    logic               busy;

    modport master (
        output din, sel, mode, start, dwell, en_mask,
        input  dout, dout_ch, dout_valid, busy
    );

    modport slave (
        input  din, sel, mode, start, dwell, en_mask,
        output dout, dout_ch, dout_valid, busy
    );
endinterface

// File: rtl/param_mux_scan.sv
// rtl/param_mux_scan.sv - N-channel registered mux with manual select and one-shot dwell scan
module param_mux_scan #(
    parameter int N_CH    = 8,
    parameter int DW      = 8,
    parameter int DWELL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    param_mux_scan_if.slave  bus
);
    localparam int SEL_W = $clog2(N_CH);
    // One extra bit so the range test is meaningful when N_CH is a power of two.
    localparam logic [SEL_W:0] CH_LIMIT = (SEL_W+1)'(N_CH);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t             state, state_next;
    logic [SEL_W-1:0]   ptr, first_ch, next_ch;
    logic               has_next;
    logic [DWELL_W-1:0] cnt, dwell_l;
    logic [N_CH-1:0]    mask_l;
    logic [DW-1:0]      sel_data, ptr_data;
    logic               sel_ok, scan_go, dwell_done;

    assign sel_ok   = ({1'b0, bus.sel} < CH_LIMIT);
    assign bus.busy = (state == SCAN);

    // Descending loops so the last hit is the lowest qualifying channel.
    always_comb begin
        sel_data = '0;
        ptr_data = '0;
        first_ch = '0;
        next_ch  = '0;
        has_next = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (bus.sel == SEL_W'(i)) sel_data = bus.din[i*DW +: DW];
            if (ptr == SEL_W'(i))     ptr_data = bus.din[i*DW +: DW];
            if (bus.en_mask[i])       first_ch = SEL_W'(i);
            if (mask_l[i] && (SEL_W'(i) > ptr)) begin
                next_ch  = SEL_W'(i);
                has_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        scan_go    = 1'b0;
        dwell_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mode && bus.start && (|bus.en_mask)) begin
                    state_next = SCAN;
                    scan_go    = 1'b1;
                end
            end
            SCAN: begin
                dwell_done = (cnt == dwell_l);
                if (dwell_done && !has_next) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dout       <= '0;
            bus.dout_ch    <= '0;
            bus.dout_valid <= 1'b0;
            ptr            <= '0;
            cnt            <= '0;
            mask_l         <= '0;
            dwell_l        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.mode) begin
                        bus.dout       <= sel_ok ? sel_data : '0;
                        bus.dout_ch    <= bus.sel;
                        bus.dout_valid <= sel_ok;
                    end else begin
                        bus.dout_valid <= 1'b0;
                    end
                    if (scan_go) begin
                        mask_l  <= bus.en_mask;
                        dwell_l <= bus.dwell;
                        ptr     <= first_ch;
                        cnt     <= '0;
                    end
                end
                SCAN: begin
                    if (!dwell_done) begin
                        cnt            <= cnt + 1'b1;
                        bus.dout_valid <= 1'b0;
                    end else begin
                        bus.dout       <= ptr_data;
                        bus.dout_ch    <= ptr;
                        bus.dout_valid <= 1'b1;
                        cnt            <= '0;
                        if (has_next) ptr <= next_ch;
                    end
                end
                default: bus.dout_valid <= 1'b0;
            endcase
        end
    end
endmodule
